// File: rtl/ccheck_pkg.sv
// Shared definitions for the CPU trace capture buffer: default record geometry,
// channel naming and a helper to pull one channel out of a packed record.
package ccheck_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_NUM_CH = 6;

    typedef enum logic [2:0] {
        CH_RS     = 3'd0,
        CH_RT     = 3'd1,
        CH_RD     = 3'd2,
        CH_BRANCH = 3'd3,
        CH_JUMP   = 3'd4,
        CH_LW     = 3'd5
    } ch_e;

    // Channel k lives at bits [k*DATA_W +: DATA_W] of a default-geometry record.
    function automatic logic [DEFAULT_DATA_W-1:0] get_ch(
        input logic [DEFAULT_NUM_CH*DEFAULT_DATA_W-1:0] rec,
        input ch_e                                      k
    );
        return rec[int'(k)*DEFAULT_DATA_W +: DEFAULT_DATA_W];
    endfunction

endpackage

// File: rtl/ccheck_trace_mem.sv
// Storage array for the trace buffer: one synchronous write port, one
// asynchronous read port, contents deliberately left unreset.
module ccheck_trace_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 192
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ccheck_trace_buf.sv
// Capture FIFO between the CPU trace tap and the checker, with overrun counting.
// Define CCHECK_SEQ_EN to tag every record with a sequence number (rec_seq port).
module ccheck_trace_buf
    import ccheck_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tap_valid,
    input  logic [NUM_CH*DATA_W-1:0] tap_data,
    input  logic                     flush,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [NUM_CH*DATA_W-1:0] rec_data,
`ifdef CCHECK_SEQ_EN
    output logic [SEQ_W-1:0]         rec_seq,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = NUM_CH * DATA_W;
`ifdef CCHECK_SEQ_EN
    localparam int ENTRY_W = REC_W + SEQ_W;
`else
    localparam int ENTRY_W = REC_W;
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SEQ_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("ccheck_trace_buf: DEPTH must be a power of two >= 2, SEQ_W and CNT_W >= 1");
    end

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshake: a record transfers on any cycle where rec_valid && rec_ready;
    // rec_valid never depends on rec_ready, and the head stays put until taken.
    // The tap side has no back-pressure: a record arriving at a full buffer
    // with no concurrent pop is dropped and counted.
    assign rec_valid = (level != '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign pop       = rec_valid && rec_ready;
    assign push      = tap_valid && (!full || pop);
    assign drop      = tap_valid && full && !pop;

`ifdef CCHECK_SEQ_EN
    logic [SEQ_W-1:0] seq_cnt;

    // Counts every offered record, dropped ones included, so gaps are visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_cnt <= '0;
        end else if (tap_valid) begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
        end
    end

    assign wr_entry = {seq_cnt, tap_data};
    assign rec_seq  = rec_valid ? rd_entry[REC_W +: SEQ_W] : '0;
`else
    assign wr_entry = tap_data;
`endif

    // Empty slots read back as zero so outputs never expose stale/unreset storage.
    assign rec_data = rec_valid ? rd_entry[REC_W-1:0] : '0;

    ccheck_trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush && !reset),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/ccheck_trace_buf.md
# ccheck_trace_buf

Parametrised capture buffer between the CPU tap point and the checker. Each cycle the CPU may present one trace record of NUM_CH DATA_W-bit channels (default six: rs, rt, rd, branch address, jump address, load data). The block stores records in a DEPTH-entry FIFO and hands them to the checker over a valid/ready handshake. A checker stall therefore no longer loses CPU state, and any overrun is counted and flagged.

## Interface
- DATA_W, 32, width of one channel
- NUM_CH, 6, channels per record; channel k occupies bits [k*DATA_W +: DATA_W]
- DEPTH, 8, FIFO entries; power of two, at least 2
- SEQ_W, 16, sequence-tag width (used only with CCHECK_SEQ_EN)
- CNT_W, 16, drop-counter width

- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- tap_valid  input  1  CPU presents a record this cycle (no back-pressure to CPU)
- tap_data  input  NUM_CH*DATA_W  packed record
- flush  input  1  discard all buffered records
- rec_valid  output  1  head record available
- rec_ready  input  1  checker accepts head
- rec_data  output  NUM_CH*DATA_W  head record
- rec_seq  output  SEQ_W  head record's sequence tag (CCHECK_SEQ_EN only)
- level  output  $clog2(DEPTH)+1  entries held
- overflow  output  1  sticky: at least one record dropped
- drop_cnt  output  CNT_W  records dropped, saturating

## Operation
- Push: tap_valid and (not full, or pop in the same cycle) -> record written at the write pointer.
- Drop: tap_valid and full and no pop -> record discarded, overflow set, drop_cnt incremented. drop_cnt saturates at all-ones.
- Pop: rec_valid and rec_ready -> read pointer advances.
- rec_valid = level != 0. rec_data/rec_seq are read from the read pointer.
- rec_data must hold stable while rec_valid is high and rec_ready is low.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level tracks occupancy: +1 on push only, −1 on pop only, unchanged on push and pop together.
- Simultaneous push and pop when full: both take effect, level stays DEPTH, nothing dropped.
- Push and pop when level = 1: the old head leaves and the new record becomes the head the next cycle.
- flush: pointers and level go to 0. Any same-cycle push or pop is ignored, and the ignored push does not count as a drop. overflow and drop_cnt are kept. The sequence counter is not reset.
- Reset: all state cleared; mid-operation reset discards buffered records.

## Timing
- Push in cycle N -> visible on rec_valid/rec_data in cycle N+1 (one-cycle latency, no bypass).
- Pop in cycle N -> next head, or rec_valid low, in cycle N+1.
- overflow, drop_cnt and level update in the cycle after the triggering edge event. All outputs are registered or decoded from registers only; there is no combinational path from tap_* or rec_ready to any output.
- Reset values: rec_valid 0, rec_data 0, rec_seq 0, level 0, overflow 0, drop_cnt 0.

## Configuration
- CCHECK_SEQ_EN defined: the block keeps an SEQ_W-bit sequence counter, reset to 0.
  - The counter increments on every tap_valid cycle, whether the record is accepted or dropped, and wraps modulo 2^SEQ_W.
  - Each accepted record stores the counter value before the increment. The checker detects gaps from non-consecutive rec_seq.
  - The rec_seq port exists.
- CCHECK_SEQ_EN undefined: no counter, no storage, and no rec_seq port. All other behaviour is identical.

## Structure
- Package ccheck_pkg holds:
  - default DATA_W, NUM_CH
  - channel-index enum ch_e: CH_RS=0, CH_RT, CH_RD, CH_BRANCH, CH_JUMP, CH_LW
  - a function extracting channel k from a packed record
- One sub-module, ccheck_trace_mem: DEPTH x width register array, one synchronous write port, one asynchronous read port. It has no reset on its contents.
- Pointer, level, drop and sequence logic stay in the top module.

## Test plan
- Reset, then push a single record with channels 0x11..0x66 -> rec_valid rises next cycle. Checker extracts CH_RD = 0x33; level = 1.
- Push 8 records with rec_ready low, then a 9th -> level = 8, overflow = 1, drop_cnt = 1. Drain returns records 1–8 in order. With CCHECK_SEQ_EN, rec_seq 0–7, and the next accepted record carries seq 9.
- Full FIFO, tap_valid and rec_ready high for 20 cycles -> no drops, level stays 8, output order matches input order across pointer wrap.
- Hold rec_ready low for 5 cycles with 3 entries buffered -> rec_data unchanged throughout.
- Flush with 5 entries buffered and tap_valid high in the same cycle -> next cycle level = 0, rec_valid = 0, drop_cnt unchanged.
- Set drop_cnt to CNT_W=4 saturation with 20 drops -> drop_cnt = 15. Reset asserted mid-stream -> all outputs return to reset values the next cycle.
